// File: rtl/selectedcard_renderer.sv
// Read-side client of the selected-card sprite memory: hit-tests the scan position
// against a per-frame latched card box, fetches sprite texels and realigns them with the scan.
module selectedcard_renderer #(
  parameter int SPR_W     = 16,
  parameter int SPR_H     = 32,
  parameter int BLINK_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] hcount,
  input  logic [7:0] vcount,
  input  logic       pixel_en,
  input  logic       frame_start,
  input  logic [7:0] card_x,
  input  logic [7:0] card_y,
  input  logic       show,
  input  logic       blink_en,
  output logic       RE,
  output logic [8:0] rAddr,
  input  logic [2:0] ramData,
  output logic [2:0] pixColor,
  output logic       pixValid
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);

  logic [7:0] sx_reg, sy_reg;
  logic       sshow_reg, sblink_reg;
  logic [4:0] fcnt_reg;
  logic       hit_d1_reg, hit_d2_reg;

  logic          hidden;
  logic [8:0]    h9, v9, x_lo, y_lo, x_hi, y_hi;
  logic          in_x, in_y, hit;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic [8:0]    addr;

  // Box bounds are widened to 9 bits so a card near the right/bottom edge clips instead of wrapping.
  always_comb begin
    hidden = sblink_reg & fcnt_reg[BLINK_BIT];
    h9     = {1'b0, hcount};
    v9     = {1'b0, vcount};
    x_lo   = {1'b0, sx_reg};
    y_lo   = {1'b0, sy_reg};
    x_hi   = x_lo + 9'(SPR_W);
    y_hi   = y_lo + 9'(SPR_H);
    in_x   = (h9 >= x_lo) && (h9 < x_hi);
    in_y   = (v9 >= y_lo) && (v9 < y_hi);
    hit    = pixel_en & sshow_reg & ~hidden & in_x & in_y;
    dx     = hcount[XW-1:0] - sx_reg[XW-1:0];
    dy     = vcount[YW-1:0] - sy_reg[YW-1:0];
    addr   = {dy, dx};
  end

  // Shadow state: a pixel coincident with frame_start still sees the previous frame's values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sx_reg     <= '0;
      sy_reg     <= '0;
      sshow_reg  <= 1'b0;
      sblink_reg <= 1'b0;
      fcnt_reg   <= '0;
    end else if (frame_start) begin
      sx_reg     <= card_x;
      sy_reg     <= card_y;
      sshow_reg  <= show;
      sblink_reg <= blink_en;
      fcnt_reg   <= fcnt_reg + 5'd1;
    end
  end

  // Three-stage pipeline: request, memory access, colour output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      RE         <= 1'b0;
      rAddr      <= '0;
      hit_d1_reg <= 1'b0;
      hit_d2_reg <= 1'b0;
      pixColor   <= '0;
      pixValid   <= 1'b0;
    end else begin
      RE         <= hit;
      hit_d1_reg <= hit;
      hit_d2_reg <= hit_d1_reg;
      if (hit)
        rAddr <= addr;
      pixColor <= hit_d2_reg ? ramData : 3'b000;
      pixValid <= hit_d2_reg && (ramData != 3'b000);
    end
  end

endmodule

// File: doc/selectedcard_renderer.md
# selectedcard_renderer

Read-side client of the `selectedcard` sprite memory (512 × 3-bit, 16 wide × 32 tall, row-major). It tracks the VGA scan position of the 256×240 display and issues read requests to the memory when the scan is inside the selected card's box. It then realigns the memory's registered read data with the scan pipeline and presents a colour plus an overlay-valid flag to the pixel mux. Card position, visibility and blink are latched once per frame to avoid tearing.

## Interface
Parameters:
- `SPR_W`, 16, sprite width in pixels (power of two, fixed 16 for the 512-entry memory)
- `SPR_H`, 32, sprite height in lines
- `BLINK_BIT`, 4, frame-counter bit that gates blinking (period 2^(BLINK_BIT+1) frames)

Ports:
- `clock` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `hcount` in 8: current scan column 0..255
- `vcount` in 8: current scan line 0..239
- `pixel_en` in 1: high when hcount/vcount are a visible pixel
- `frame_start` in 1: one-cycle pulse at start of each frame
- `card_x` in 8: top-left column of selected card
- `card_y` in 8: top-left line of selected card
- `show` in 1: card overlay enable
- `blink_en` in 1: enable blinking
- `RE` out 1: read enable to memory
- `rAddr` out 9: read address to memory
- `ramData` in 3: memory `dataOut`, valid one cycle after `RE`/`rAddr` are sampled
- `pixColor` out 3: overlay colour
- `pixValid` out 1: overlay pixel is opaque and shown

## Operation
- Shadow registers `sx`, `sy`, `sshow`, `sblink` load from `card_x`, `card_y`, `show`, `blink_en` only on edges where `frame_start` = 1.
- `fcnt` is a 5-bit frame counter. It increments on `frame_start` and wraps 31→0.
- `hidden` = `sblink & fcnt[BLINK_BIT]`.
- Hit test uses 9-bit arithmetic with no 8-bit wrap:
  - hit = `pixel_en & sshow & ~hidden`
  - and `hcount ≥ sx` and `hcount < sx+16`
  - and `vcount ≥ sy` and `vcount < sy+32`
- dx = hcount−sx (4 bits); dy = vcount−sy (5 bits); address = {dy, dx} = dy·16+dx.
- Stage 0, registered at edge k: `RE` ← hit; `rAddr` ← address if hit, else holds its previous value. `hit_d1` ← hit.
- Stage 1, edge k+1: the memory produces `ramData`. `hit_d2` ← `hit_d1`.
- Stage 2, edge k+2:
  - `pixColor` ← `ramData` if `hit_d2`, else 0.
  - `pixValid` ← `hit_d2` and `ramData` ≠ 3'b000. Colour 000 is transparent.
- Card partly off-screen (e.g. sx = 250): only columns 250..255 hit; no wrap to column 0. The same rule applies to sy > 208 at the bottom.
- Simultaneous `frame_start` and `pixel_en` on edge k: the pixel at edge k uses the old shadow values; new values apply from edge k+1.
- The block never writes the memory; WE ownership stays with the memory's writer.

## Timing
- Latency: scan coordinates sampled at edge k → `pixColor`/`pixValid` valid after edge k+2. The pixel mux delays its background by 2 cycles to match.
- Throughput: one pixel per clock, fully pipelined, no stalls.
- `RE` is high only for hit pixels; `rAddr` changes only when `RE` is high.
- Reset (asynchronous, immediate): `RE` = 0, `rAddr` = 0, `pixColor` = 0, `pixValid` = 0, `fcnt` = 0, `sx` = `sy` = 0, `sshow` = 0, `sblink` = 0, pipeline flags cleared.
- Reset mid-line: outputs drop to 0 asynchronously. After release, nothing shows until the next `frame_start` loads `sshow`.

## Test plan
- Basic hit:
  - stimulus: memory preloaded with addr[2:0] pattern; card_x = 10, card_y = 20, show = 1; one frame_start; scan line 20, hcount 8..28.
  - response: RE high exactly for hcount 10..25; rAddr 0..15.
  - response: pixColor = rAddr[2:0] two cycles later; pixValid low where the value is 000.
- Row addressing: scan line 51 (dy = 31), hcount 10 → rAddr = 496; line 52 → no RE.
- Right-edge clip: card_x = 250 → RE for hcount 250..255 only (rAddr 0..5 on line card_y). pixValid never asserts at hcount 0..9 of the same line.
- Blink:
  - blink_en = 1 over 64 frames.
  - response: sprite visible in frames where fcnt[4] = 0 (frames 0–15, 32–47); RE and pixValid stay 0 in frames 16–31 and 48–63.
- Tear-free update: change card_x from 10 to 100 mid-frame → the current frame still hits at 10..25; the frame after the next frame_start hits at 100..115.
- Reset: assert reset while pixValid = 1 → pixValid/RE go 0 without a clock edge. After release and one frame_start with show = 1, normal output resumes.
